mvu_data_transposer: RTL and testbench
======================================

Name: mvu_data_transposer

Overview:
- Converts packed multi-bit elements written by the RV32 core into bit-plane (transposed) words for an MVU input data RAM.
- Collects enough XLEN-wide input words to fill NUM_WORDS elements, then writes `prec` bit-plane words to consecutive MVU addresses.
- One instance per MVU, sitting between the accelerator's host-side data port and the MVU write-controller port.

Parameters:
- NUM_WORDS, 64: elements per output word (lanes); must equal MVU_DATA_LEN.
- XLEN, 32: input word width.
- MVU_ADDR_LEN, 15: MVU RAM address width.
- MVU_DATA_LEN, 64: MVU RAM word width.
- MAX_DATA_PREC, 8: largest supported element precision in bits; sizes the internal buffer (NUM_WORDS*MAX_DATA_PREC bits).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- prec  in  32  element precision in bits; sampled on start.
- baddr  in  32  base write address; low MVU_ADDR_LEN bits sampled on start.
- iword  in  XLEN  packed input word; element i occupies bits [i*prec +: prec].
- start  in  1  pulse; the iword of this cycle is the first word of a block.
- valid  in  1  iword valid during LOAD (ignored in the start cycle).
- busy  out  1  high from the cycle after an accepted start until the write phase completes.
- mvu_wr_en  out  1  MVU RAM write enable.
- mvu_wr_addr  out  MVU_ADDR_LEN  MVU RAM write address.
- mvu_wr_word  out  MVU_DATA_LEN  MVU RAM write data.

Behaviour:
- Reset: state IDLE; busy, mvu_wr_en, mvu_wr_addr and mvu_wr_word are 0; buffer and counters cleared.
- Reset asserted mid-operation aborts immediately with the same values. No partial write is completed.
- Legal prec values: 1, 2, 4, 8, 16 or 32, and also ≤ MAX_DATA_PREC. A start with any other prec is ignored and the block stays IDLE.
- Input words per block: W = NUM_WORDS*prec/XLEN. Examples with defaults: prec=1 → 2, prec=2 → 4, prec=8 → 16.
- IDLE:
  - On start with legal prec: latch prec and baddr, store iword as word 0, go to LOAD.
  - If W==1, go directly to WRITE.
- LOAD:
  - Each cycle with valid=1 stores iword as the next word. Word k holds elements k*(XLEN/prec) onward.
  - After word W-1 is stored, go to WRITE.
  - start is ignored while in LOAD.
- WRITE: lasts exactly prec cycles, k = 0..prec-1.
  - mvu_wr_en = 1.
  - mvu_wr_addr = latched baddr + k, with wrap modulo 2^MVU_ADDR_LEN.
  - mvu_wr_word bit j = bit (prec-1-k) of element j, so the MSB plane is written first.
  - After the last write, return to IDLE. busy and mvu_wr_en deassert on the following cycle.
  - start is ignored in WRITE, including the final WRITE cycle.
- Latency: the first write is registered and appears the cycle after the last input word is accepted.
- busy = 1 in LOAD and WRITE, 0 in IDLE.
- Outputs are registered. When mvu_wr_en=0, addr and word hold 0.

Optional Feature:
- Macro DT_LSB_FIRST_EN.
- When defined: in WRITE, word k carries bit-plane k (LSB plane first, at baddr).
- When undefined: MSB plane first, as in Behaviour.
- Address sequence and timing are identical in both cases.

Test Plan:
- prec=1, baddr=0x100, start with iword=0xAAAAAAAA, then valid with 0x0000FFFF → exactly one write: addr 0x100, word 0x0000FFFF_AAAAAAAA. busy low 1 cycle after the write.
- prec=2, baddr=0x20, four words of 0x55555555 → writes addr 0x20 = 0x0, then addr 0x21 = 0xFFFFFFFF_FFFFFFFF. With DT_LSB_FIRST_EN defined the order of the two words is swapped.
- prec=8, 16 words each 0x80808080 → 8 writes at baddr..baddr+7: first word all ones, the remaining 7 all zero.
- Gaps: prec=1 with valid low for 3 cycles between words → result identical to the gap-free case, busy held high throughout.
- Illegal prec=3 or prec=16 (MAX_DATA_PREC=8) with start → busy stays 0 and no writes. A start pulse during LOAD has no effect.
- Reset asserted during WRITE of a prec=8 block → all outputs 0 asynchronously. After release, a new prec=1 block completes correctly.
- baddr=0x7FFF, prec=2 → writes at 0x7FFF then 0x0000.

Source files
------------

// File: rtl/mvu_data_transposer.sv
// Packs XLEN-wide host words into a buffer and emits bit-plane words to an MVU data RAM.
// Optional macro DT_LSB_FIRST_EN: emit the LSB plane first instead of the MSB plane.
module mvu_data_transposer #(
  parameter int NUM_WORDS     = 64,
  parameter int XLEN          = 32,
  parameter int MVU_ADDR_LEN  = 15,
  parameter int MVU_DATA_LEN  = 64,
  parameter int MAX_DATA_PREC = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             prec,
  input  logic [31:0]             baddr,
  input  logic [XLEN-1:0]         iword,
  input  logic                    start,
  input  logic                    valid,
  output logic                    busy,
  output logic                    mvu_wr_en,
  output logic [MVU_ADDR_LEN-1:0] mvu_wr_addr,
  output logic [MVU_DATA_LEN-1:0] mvu_wr_word
);

  localparam int BB   = NUM_WORDS * MAX_DATA_PREC;
  localparam int BIW  = $clog2(BB);
  localparam int WMAX = BB / XLEN;
  localparam int CW   = $clog2(WMAX + 1);
  localparam int PW   = $clog2(MAX_DATA_PREC + 1);

`ifdef DT_LSB_FIRST_EN
  localparam bit LSB_FIRST = 1'b1;
`else
  localparam bit LSB_FIRST = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WRITE
  } state_t;

  state_t                    state, state_n;
  logic [PW-1:0]             prec_r, prec_n;
  logic [MVU_ADDR_LEN-1:0]   base_r, base_n;
  logic [CW-1:0]             wcnt, wcnt_n;
  logic [CW-1:0]             wtot, wtot_n;
  logic [PW-1:0]             pcnt, pcnt_n;
  logic [BB-1:0]             data, data_n;
  logic [BIW-1:0]            wbase;
  logic [MVU_DATA_LEN-1:0]   word_n;

  logic unused_baddr;
  assign unused_baddr = ^baddr[31:MVU_ADDR_LEN];

  function automatic logic legal(input logic [31:0] p);
    logic pow;
    pow = (p == 32'd1) || (p == 32'd2) || (p == 32'd4) ||
          (p == 32'd8) || (p == 32'd16) || (p == 32'd32);
    return pow && (p <= 32'(MAX_DATA_PREC));
  endfunction

  // Next-state logic: latch config on start, collect words, step planes.
  always_comb begin
    state_n = state;
    prec_n  = prec_r;
    base_n  = base_r;
    wcnt_n  = wcnt;
    wtot_n  = wtot;
    pcnt_n  = pcnt;
    data_n  = data;
    wbase   = '0;
    unique case (state)
      IDLE: begin
        if (start && legal(prec)) begin
          prec_n            = PW'(prec);
          base_n            = baddr[MVU_ADDR_LEN-1:0];
          data_n[XLEN-1:0]  = iword;
          wtot_n            = CW'(NUM_WORDS * int'(prec_n) / XLEN);
          wcnt_n            = CW'(1);
          pcnt_n            = '0;
          state_n           = (wtot_n == CW'(1)) ? WRITE : LOAD;
        end
      end
      LOAD: begin
        if (valid) begin
          wbase                 = BIW'(int'(wcnt) * XLEN);
          data_n[wbase +: XLEN] = iword;
          wcnt_n                = wcnt + CW'(1);
          if (wcnt_n == wtot) state_n = WRITE;
        end
      end
      WRITE: begin
        if (int'(pcnt) == int'(prec_r) - 1) begin
          state_n = IDLE;
          pcnt_n  = '0;
        end else begin
          pcnt_n  = pcnt + PW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Gather the selected bit plane from the next buffer so the first write
  // can leave on the edge that accepts the last input word.
  always_comb begin
    int pl;
    int idx;
    word_n = '0;
    pl     = LSB_FIRST ? int'(pcnt_n) : int'(prec_n) - 1 - int'(pcnt_n);
    idx    = 0;
    for (int j = 0; j < NUM_WORDS; j++) begin
      idx = j * int'(prec_n) + pl;
      if (idx >= 0 && idx < BB) word_n[j] = data_n[BIW'(idx)];
    end
  end

  // Control and buffer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      prec_r <= '0;
      base_r <= '0;
      wcnt   <= '0;
      wtot   <= '0;
      pcnt   <= '0;
      data   <= '0;
    end else begin
      state  <= state_n;
      prec_r <= prec_n;
      base_r <= base_n;
      wcnt   <= wcnt_n;
      wtot   <= wtot_n;
      pcnt   <= pcnt_n;
      data   <= data_n;
    end
  end

  // Registered outputs; address and data are zero whenever no write is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy        <= 1'b0;
      mvu_wr_en   <= 1'b0;
      mvu_wr_addr <= '0;
      mvu_wr_word <= '0;
    end else begin
      busy <= (state_n != IDLE);
      if (state_n == WRITE) begin
        mvu_wr_en   <= 1'b1;
        mvu_wr_addr <= base_n + MVU_ADDR_LEN'(pcnt_n);
        mvu_wr_word <= word_n;
      end else begin
        mvu_wr_en   <= 1'b0;
        mvu_wr_addr <= '0;
        mvu_wr_word <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mvu_data_transposer.sv
// Directed bench for mvu_data_transposer.
// Expected bit planes are hand-derived from the input patterns.
module tb_mvu_data_transposer;

  logic        clk;
  logic        rst;
  logic [31:0] prec;
  logic [31:0] baddr;
  logic [31:0] iword;
  logic        start;
  logic        valid;
  logic        busy;
  logic        mvu_wr_en;
  logic [14:0] mvu_wr_addr;
  logic [63:0] mvu_wr_word;

  int checks;
  int failures;

  logic [14:0] wa[$];
  logic [63:0] ww[$];

`ifdef DT_LSB_FIRST_EN
  localparam bit LSB = 1'b1;
`else
  localparam bit LSB = 1'b0;
`endif

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  mvu_data_transposer dut (
    .clk         (clk),
    .rst         (rst),
    .prec        (prec),
    .baddr       (baddr),
    .iword       (iword),
    .start       (start),
    .valid       (valid),
    .busy        (busy),
    .mvu_wr_en   (mvu_wr_en),
    .mvu_wr_addr (mvu_wr_addr),
    .mvu_wr_word (mvu_wr_word)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Log every issued write.
  always @(negedge clk) begin
    if (mvu_wr_en) begin
      wa.push_back(mvu_wr_addr);
      ww.push_back(mvu_wr_word);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clr();
    wa.delete();
    ww.delete();
  endtask

  task automatic feed(input logic [31:0] p, input logic [31:0] a,
                      input logic [31:0] w0, input logic [31:0] w1,
                      input int n, input int gap, input bit fin);
    @(negedge clk);
    start = 1'b1; prec = p; baddr = a; iword = w0; valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < n; i++) begin
      for (int g = 0; g < gap; g++) begin
        valid = 1'b0;
        @(negedge clk);
        chk("gap_busy", 64'(busy), 64'd1);
      end
      valid = 1'b1; iword = w1;
      @(negedge clk);
    end
    valid = 1'b0;
    if (fin) begin
      for (int c = 0; c < 40 && busy; c++) @(negedge clk);
      chk("done", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; prec = '0; baddr = '0; iword = '0;
    start = 1'b0; valid = 1'b0;
    #3;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_en",   64'(mvu_wr_en), 64'd0);
    chk("rst_addr", 64'(mvu_wr_addr), 64'd0);
    chk("rst_word", mvu_wr_word, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clr();

    // prec=1, cycle by cycle
    start = 1'b1; prec = 32'd1; baddr = 32'h100; iword = 32'hAAAA_AAAA;
    @(negedge clk);
    chk("t1_busy_load", 64'(busy), 64'd1);
    chk("t1_en_load",   64'(mvu_wr_en), 64'd0);
    start = 1'b0; valid = 1'b1; iword = 32'h0000_FFFF;
    @(negedge clk);
    valid = 1'b0;
    chk("t1_en",   64'(mvu_wr_en), 64'd1);
    chk("t1_addr", 64'(mvu_wr_addr), 64'h100);
    chk("t1_word", mvu_wr_word, 64'h0000_FFFF_AAAA_AAAA);
    chk("t1_busy", 64'(busy), 64'd1);
    @(negedge clk);
    chk("t1_en_off",   64'(mvu_wr_en), 64'd0);
    chk("t1_busy_off", 64'(busy), 64'd0);
    chk("t1_addr_off", 64'(mvu_wr_addr), 64'd0);
    chk("t1_word_off", mvu_wr_word, 64'd0);
    chk("t1_n", 64'(wa.size()), 64'd1);
    clr();

    // prec=2, elements all 01
    feed(32'd2, 32'h20, 32'h5555_5555, 32'h5555_5555, 4, 0, 1'b1);
    chk("t2_n", 64'(wa.size()), 64'd2);
    if (wa.size() == 2) begin
      chk("t2_a0", 64'(wa[0]), 64'h20);
      chk("t2_a1", 64'(wa[1]), 64'h21);
      chk("t2_w0", ww[0], LSB ? ONES : 64'd0);
      chk("t2_w1", ww[1], LSB ? 64'd0 : ONES);
    end
    clr();

    // prec=8, elements all 0x80
    feed(32'd8, 32'h300, 32'h8080_8080, 32'h8080_8080, 16, 0, 1'b1);
    chk("t3_n", 64'(wa.size()), 64'd8);
    if (wa.size() == 8) begin
      for (int k = 0; k < 8; k++) begin
        chk("t3_a", 64'(wa[k]), 64'h300 + 64'(k));
        chk("t3_w", ww[k], (k == (LSB ? 7 : 0)) ? ONES : 64'd0);
      end
    end
    clr();

    // prec=1 with 3-cycle valid gaps
    feed(32'd1, 32'h140, 32'hAAAA_AAAA, 32'h0000_FFFF, 2, 3, 1'b1);
    chk("gap_n", 64'(wa.size()), 64'd1);
    if (wa.size() == 1) begin
      chk("gap_a", 64'(wa[0]), 64'h140);
      chk("gap_w", ww[0], 64'h0000_FFFF_AAAA_AAAA);
    end
    clr();

    // illegal precisions
    feed(32'd3, 32'h10, 32'h1, 32'h1, 1, 0, 1'b1);
    repeat (3) @(negedge clk);
    chk("ill3_busy", 64'(busy), 64'd0);
    feed(32'd16, 32'h10, 32'h1, 32'h1, 1, 0, 1'b1);
    repeat (3) @(negedge clk);
    chk("ill16_busy", 64'(busy), 64'd0);
    chk("ill_n", 64'(wa.size()), 64'd0);
    clr();

    // start pulse during LOAD is ignored
    @(negedge clk);
    start = 1'b1; prec = 32'd1; baddr = 32'h10; iword = 32'h1234_5678;
    @(negedge clk);
    prec = 32'd2; baddr = 32'h55; iword = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; valid = 1'b1; iword = 32'h9ABC_DEF0;
    @(negedge clk);
    valid = 1'b0;
    for (int c = 0; c < 40 && busy; c++) @(negedge clk);
    chk("sl_n", 64'(wa.size()), 64'd1);
    if (wa.size() == 1) begin
      chk("sl_a", 64'(wa[0]), 64'h10);
      chk("sl_w", ww[0], 64'h9ABC_DEF0_1234_5678);
    end
    clr();

    // reset during WRITE of a prec=8 block
    feed(32'd8, 32'h300, 32'h8080_8080, 32'h8080_8080, 16, 0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("rw_en_pre", 64'(mvu_wr_en), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rw_busy", 64'(busy), 64'd0);
    chk("rw_en",   64'(mvu_wr_en), 64'd0);
    chk("rw_addr", 64'(mvu_wr_addr), 64'd0);
    chk("rw_word", mvu_wr_word, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    clr();
    repeat (3) @(negedge clk);
    chk("rw_quiet", 64'(wa.size()), 64'd0);
    feed(32'd1, 32'h100, 32'hAAAA_AAAA, 32'h0000_FFFF, 2, 0, 1'b1);
    chk("rw2_n", 64'(wa.size()), 64'd1);
    if (wa.size() == 1) begin
      chk("rw2_a", 64'(wa[0]), 64'h100);
      chk("rw2_w", ww[0], 64'h0000_FFFF_AAAA_AAAA);
    end
    clr();

    // address wrap
    feed(32'd2, 32'h7FFF, 32'h5555_5555, 32'h5555_5555, 4, 0, 1'b1);
    chk("wr_n", 64'(wa.size()), 64'd2);
    if (wa.size() == 2) begin
      chk("wr_a0", 64'(wa[0]), 64'h7FFF);
      chk("wr_a1", 64'(wa[1]), 64'h0000);
      chk("wr_w0", ww[0], LSB ? ONES : 64'd0);
      chk("wr_w1", ww[1], LSB ? 64'd0 : ONES);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
